// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo enqueue arbiter.
// The round-robin helper works on a fixed-width vector so that any
// requester count up to RR_MAX_REQ can use it without re-elaboration.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB_RUN  = 2'd0,
        ARB_CLR  = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_t;

    // Widest requester vector the helper can scan, and the index width
    // needed to address a bit of it.
    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    // Returns the first set index of valid[n-1:0] found when scanning
    // ptr, ptr+1, ... modulo n. Returns ptr when nothing is set.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input int unsigned           ptr,
        input int unsigned           n
    );
        int unsigned j;
        int unsigned pick;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            if ((k < n) && !found) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (valid[j[RR_IDX_W-1:0]]) begin
                    pick  = j;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: selects the first valid
// requester at or after the start pointer, wrapping at NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [RR_MAX_REQ-1:0] valid_ext;
    int unsigned           pick;

    // Widen the request vector, run the shared scan and map the result
    // back onto a requester index.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no latch).
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = valid;
        pick                   = rr_pick(valid_ext, 32'(ptr), NUM_REQ);
        idx                    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick == i) begin
                idx = IDX_W'(i);
            end
        end
        any = |valid;
    end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Shares one fifo enqueue port among NUM_REQ producers.
// Round-robin arbitration with a burst lock of up to MAX_BURST words per
// winner, source-ID tagging on fifo_din, and a flush sequence that
// strobes fifo_clr then stays quiet for CLR_HOLD cycles before resuming.
module fifo_enq_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 2,
    parameter int CLR_HOLD   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
    output logic                           fifo_enq,
    input  logic                           fifo_full_n,
    output logic                           fifo_clr,
    input  logic                           flush_req,
    output logic                           flush_done
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int CNT_W     = $clog2(MAX_BURST + 1);
    localparam int HOLD_W    = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
    // The counter is loaded in CLR and the last quiet cycle is the one
    // where it reads zero, giving exactly CLR_HOLD HOLD cycles.
    localparam int HOLD_LOAD = (CLR_HOLD > 0) ? CLR_HOLD - 1 : 0;

    if (ID_WIDTH < $clog2(NUM_REQ)) begin : g_bad_id_width
        $error("fifo_enq_arbiter: ID_WIDTH too narrow for NUM_REQ");
    end
    if ((NUM_REQ < 2) || (NUM_REQ > int'(RR_MAX_REQ))) begin : g_bad_num_req
        $error("fifo_enq_arbiter: NUM_REQ out of range");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("fifo_enq_arbiter: MAX_BURST must be at least 1");
    end

    // Wrapping increment of a requester index.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       owner;
    logic [CNT_W-1:0]       burst_cnt;   // zero means no lock is held
    logic [HOLD_W-1:0]      hold_cnt;

    logic                   owner_valid;
    logic                   keep_owner;
    logic                   owner_dropped;
    logic [IDX_W-1:0]       scan_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic                   any_valid;
    logic [IDX_W-1:0]       grant;
    logic [CNT_W-1:0]       burst_next;
    logic                   burst_done;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   xfer;
    logic                   clr_now;
    logic                   done_now;

    // Lock status: keep the owner while it is still presenting words;
    // if it went idle, the scan restarts just past it this same cycle.
    always_comb begin
        owner_valid   = req_valid[owner];
        keep_owner    = (burst_cnt != '0) && owner_valid;
        owner_dropped = (burst_cnt != '0) && !owner_valid;
        scan_ptr      = owner_dropped ? next_idx(owner) : rr_ptr;
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .valid (req_valid),
        .ptr   (scan_ptr),
        .idx   (pick_idx),
        .any   (any_valid)
    );

    // Final grant, the burst count it would produce, and its payload.
    always_comb begin
        grant      = keep_owner ? owner : pick_idx;
        burst_next = keep_owner ? burst_cnt + 1'b1 : CNT_W'(1);
        burst_done = (burst_next == CNT_W'(MAX_BURST));
        sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Flush sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments
        // so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= ARB_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush sequencer next state and per-state strobes.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        clr_now   = 1'b0;
        done_now  = 1'b0;
        case (state)
            ARB_RUN: begin
                xfer = fifo_full_n && any_valid && !flush_req;
                if (flush_req) begin
                    state_nxt = ARB_CLR;
                end
            end
            ARB_CLR: begin
                clr_now = 1'b1;
                if (CLR_HOLD == 0) begin
                    state_nxt = ARB_RUN;
                    done_now  = 1'b1;
                end else begin
                    state_nxt = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = ARB_RUN;
                    done_now  = 1'b1;
                end
            end
            default: begin
                state_nxt = ARB_RUN;
            end
        endcase
    end

    // Port drive; gated by rst_n so strobes fall the moment reset asserts.
    always_comb begin
        fifo_enq   = rst_n && xfer;
        fifo_clr   = rst_n && clr_now;
        flush_done = rst_n && done_now;
        req_ready  = '0;
        fifo_din   = '0;
        if (fifo_enq) begin
            req_ready[grant] = 1'b1;
            fifo_din         = {ID_WIDTH'(grant), sel_data};
        end
    end

    // Burst lock, round-robin pointer and quiet-period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ARB_RUN: begin
                    if (xfer) begin
                        if (burst_done) begin
                            rr_ptr    <= next_idx(grant);
                            burst_cnt <= '0;
                        end else begin
                            if (owner_dropped) begin
                                rr_ptr <= next_idx(owner);
                            end
                            owner     <= grant;
                            burst_cnt <= burst_next;
                        end
                    end else if (fifo_full_n && !flush_req && owner_dropped) begin
                        rr_ptr    <= next_idx(owner);
                        burst_cnt <= '0;
                    end
                end
                ARB_CLR: begin
                    rr_ptr    <= '0;
                    burst_cnt <= '0;
                    hold_cnt  <= HOLD_W'(HOLD_LOAD);
                end
                ARB_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Self-checking bench for fifo_enq_arbiter (4 requesters, 4-bit data,
// burst of 2, one quiet cycle after clear). Directed scenarios compare
// against literal expectations; the random run compares against a
// behavioural model of the arbitration rules.
module tb_fifo_enq_arbiter;

    localparam int N        = 4;
    localparam int DW       = 4;
    localparam int IW       = 2;
    localparam int MAXB     = 2;
    localparam int CLR_HOLD = 1;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [IW+DW-1:0] fifo_din;
    logic           fifo_enq;
    logic           fifo_full_n;
    logic           fifo_clr;
    logic           flush_req;
    logic           flush_done;

    int n_checks;
    int n_fail;

    fifo_enq_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MAX_BURST  (MAXB),
        .CLR_HOLD   (CLR_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_din    (fifo_din),
        .fifo_enq    (fifo_enq),
        .fifo_full_n (fifo_full_n),
        .fifo_clr    (fifo_clr),
        .flush_req   (flush_req),
        .flush_done  (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 streaming, 1 clearing, 2 quiet period
    int m_mode;
    int m_ptr;
    int m_owner;      // -1 when nobody holds the lock
    int m_cnt;
    int m_hold;       // quiet cycles still to go
    bit pending;

    logic [N-1:0]    cur_valid;
    logic [N*DW-1:0] cur_data;
    logic            cur_full;
    logic            cur_flush;

    int              e_g;
    logic            e_enq;
    logic [N-1:0]    e_ready;
    logic [IW+DW-1:0] e_din;
    logic            e_clr;
    logic            e_done;

    task automatic model_reset();
        m_mode  = 0;
        m_ptr   = 0;
        m_owner = -1;
        m_cnt   = 0;
        m_hold  = 0;
        pending = 0;
    endtask

    // Expected outputs for the inputs currently applied.
    task automatic model_expect();
        int start;
        bit found;
        logic [1:0] gid;
        start = m_ptr;
        if (m_owner >= 0 && !cur_valid[m_owner]) start = (m_owner + 1) % N;
        e_g   = start;
        found = 0;
        if (m_owner >= 0 && cur_valid[m_owner]) begin
            e_g   = m_owner;
            found = 1;
        end
        for (int k = 0; k < N; k++) begin
            if (!found && cur_valid[(start + k) % N]) begin
                e_g   = (start + k) % N;
                found = 1;
            end
        end
        e_enq   = (m_mode == 0) && cur_full && (cur_valid != 0) && !cur_flush;
        gid     = e_g[1:0];
        e_ready = e_enq ? N'(1 << e_g) : '0;
        e_din   = e_enq ? {gid, cur_data[e_g*DW +: DW]} : '0;
        e_clr   = (m_mode == 1);
        e_done  = ((m_mode == 1) && (CLR_HOLD == 0)) || ((m_mode == 2) && (m_hold == 1));
    endtask

    // Advance the model over one clock edge.
    task automatic model_commit();
        case (m_mode)
            0: begin
                if (cur_flush) begin
                    m_mode = 1;
                end else if (cur_full) begin
                    if (m_owner >= 0 && !cur_valid[m_owner]) begin
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                        m_cnt   = 0;
                    end
                    if (e_enq) begin
                        if (e_g == m_owner) begin
                            m_cnt = m_cnt + 1;
                        end else begin
                            m_owner = e_g;
                            m_cnt   = 1;
                        end
                        if (m_cnt == MAXB) begin
                            m_ptr   = (e_g + 1) % N;
                            m_owner = -1;
                            m_cnt   = 0;
                        end
                    end
                end
            end
            1: begin
                m_owner = -1;
                m_cnt   = 0;
                m_ptr   = 0;
                if (CLR_HOLD == 0) m_mode = 0;
                else begin
                    m_mode = 2;
                    m_hold = CLR_HOLD;
                end
            end
            default: begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_mode = 0;
            end
        endcase
    endtask

    // Apply one cycle of inputs at the falling edge and settle.
    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input logic f, input logic fl);
        if (pending) model_commit();
        @(negedge clk);
        req_valid   = v;
        req_data    = d;
        fifo_full_n = f;
        flush_req   = fl;
        cur_valid   = v;
        cur_data    = d;
        cur_full    = f;
        cur_flush   = fl;
        #1;
        model_expect();
        pending = 1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        fifo_full_n = 1'b1;
        flush_req   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        req_valid   = 4'hF;
        req_data    = 16'h1234;
        fifo_full_n = 1'b1;
        flush_req   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        n_checks++;
        if (fifo_enq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_enq got=%b want=0", fifo_enq);
        end
        n_checks++;
        if (fifo_clr !== 1'b0 || flush_done !== 1'b0 || fifo_din !== '0) begin
            n_fail++;
            $display("FAIL reset_clr_done_din got=%b/%b/%h want=0/0/00", fifo_clr, flush_done, fifo_din);
        end
        do_reset();
    endtask

    task automatic test_burst_lock();
        logic [5:0] exp_din [5];
        exp_din = '{6'h0C, 6'h0C, 6'h1A, 6'h1A, 6'h0C};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0011, 16'h00AC, 1'b1, 1'b0);
            n_checks++;
            if (fifo_enq !== 1'b1 || fifo_din !== exp_din[c]) begin
                n_fail++;
                $display("FAIL burst_lock[%0d] got enq=%b din=%h want enq=1 din=%h", c, fifo_enq, fifo_din, exp_din[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] exp_din [6];
        logic       full_seq [6];
        exp_din  = '{6'h0C, 6'h00, 6'h00, 6'h00, 6'h0C, 6'h1A};
        full_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(4'b0011, 16'h00AC, full_seq[c], 1'b0);
            n_checks++;
            if (fifo_enq !== full_seq[c] || fifo_din !== exp_din[c]) begin
                n_fail++;
                $display("FAIL backpressure[%0d] got enq=%b din=%h want enq=%b din=%h", c, fifo_enq, fifo_din, full_seq[c], exp_din[c]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rdy [5];
        exp_rdy = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b1010, 16'h9050, 1'b1, 1'b0);
            n_checks++;
            if (req_ready !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL rotation[%0d] got ready=%b want=%b", c, req_ready, exp_rdy[c]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) drive(4'b0011, 16'h00AC, 1'b1, 1'b0);
        drive(4'b0011, 16'h00AC, 1'b1, 1'b1);
        n_checks++;
        if (fifo_enq !== 1'b0 || fifo_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_cycle got enq=%b clr=%b want enq=0 clr=0", fifo_enq, fifo_clr);
        end
        // flush_req kept high while clearing must be ignored
        drive(4'b0011, 16'h00AC, 1'b1, 1'b1);
        n_checks++;
        if (fifo_clr !== 1'b1 || fifo_enq !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_clr got clr=%b enq=%b ready=%b want clr=1 enq=0 ready=0000", fifo_clr, fifo_enq, req_ready);
        end
        drive(4'b0011, 16'h00AC, 1'b1, 1'b0);
        n_checks++;
        if (fifo_enq !== 1'b0 || flush_done !== 1'b1 || fifo_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_hold got enq=%b done=%b clr=%b want enq=0 done=1 clr=0", fifo_enq, flush_done, fifo_clr);
        end
        drive(4'b0110, 16'h0750, 1'b1, 1'b0);
        n_checks++;
        if (req_ready !== 4'b0010 || fifo_din !== 6'h15 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resume got ready=%b din=%h done=%b want ready=0010 din=15 done=0", req_ready, fifo_din, flush_done);
        end
    endtask

    task automatic test_mid_flush_reset();
        do_reset();
        drive(4'b0011, 16'h00AC, 1'b1, 1'b0);
        drive(4'b0011, 16'h00AC, 1'b1, 1'b1);
        drive(4'b0011, 16'h00AC, 1'b1, 1'b0);
        n_checks++;
        if (fifo_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_in_clr got clr=%b want=1", fifo_clr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fifo_clr !== 1'b0 || fifo_enq !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_async got clr=%b enq=%b ready=%b want 0/0/0000", fifo_clr, fifo_enq, req_ready);
        end
        do_reset();
        drive(4'b0011, 16'h00AC, 1'b1, 1'b0);
        n_checks++;
        if (req_ready !== 4'b0001 || fifo_din !== 6'h0C) begin
            n_fail++;
            $display("FAIL midreset_resume got ready=%b din=%h want ready=0001 din=0C", req_ready, fifo_din);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic            f;
        logic            fl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v  = N'($urandom_range(0, 15));
            d  = (N*DW)'($urandom);
            f  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            // bias toward steady requesters so bursts actually form
            if ($urandom_range(0, 1) == 1) v = cur_valid | v;
            drive(v, d, f, fl);
            n_checks++;
            if (fifo_enq !== e_enq || req_ready !== e_ready) begin
                n_fail++;
                $display("FAIL rand_grant[%0d] got enq=%b ready=%b want enq=%b ready=%b", c, fifo_enq, req_ready, e_enq, e_ready);
            end
            n_checks++;
            if (fifo_din !== e_din) begin
                n_fail++;
                $display("FAIL rand_din[%0d] got=%h want=%h", c, fifo_din, e_din);
            end
            n_checks++;
            if (fifo_clr !== e_clr || flush_done !== e_done) begin
                n_fail++;
                $display("FAIL rand_flush[%0d] got clr=%b done=%b want clr=%b done=%b", c, fifo_clr, flush_done, e_clr, e_done);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cur_valid = '0;
        model_reset();
        test_reset();
        test_burst_lock();
        test_backpressure();
        test_rotation();
        test_flush();
        test_mid_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
